muldiv_serial: RTL and testbench
================================

// Module: muldiv_serial
// PURPOSE
//  Parametrised iterative multiply/divide unit for the MIPS HI/LO path. It supersedes the fixed
//  32-bit radix-2 serial multiplier.
//  Adds signed/unsigned divide, configurable width and bits-per-cycle (radix), a busy flag and
//  defined divide-by-zero/overflow results. Sits beside the EX stage; the pipeline stalls on busy.
// PARAMETERS
//  WIDTH  32  operand width in bits; even, >= 8
//  BPC    1   bits retired per cycle (1, 2 or 4); WIDTH % BPC == 0, else elaboration $error
// PORTS
//  clk    in   1        single clock, rising edge
//  rst    in   1        asynchronous, active-low reset
//  mst    in   1        start request, sampled on rising clk
//  msgn   in   1        1 = signed two's-complement operands, 0 = unsigned
//  mdiv   in   1        0 = multiply, 1 = divide
//  a      in   WIDTH    multiplicand / dividend
//  b      in   WIDTH    multiplier / divisor
//  hi     out  WIDTH    mul: product[2W-1:W]; div: remainder
//  lo     out  WIDTH    mul: product[W-1:0];  div: quotient
//  prodv  out  1        one-cycle pulse: hi/lo updated this cycle
//  busy   out  1        operation in flight; mst ignored while high
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; hi, lo, prodv, busy = 0; internal regs cleared. Mid-op reset aborts.
//  N = WIDTH/BPC iterations. FSM: IDLE -> RUN -> FIX -> IDLE.
//   IDLE: On an edge E0 with mst=1, latch |a|, |b| (magnitude only when msgn=1), the result signs,
//         mdiv and msgn, and set count = N. Enter RUN and set busy=1.
//   RUN: Each edge retires BPC bits (shift-add for mul, restoring shift-subtract for div) and
//        decrements count. Leave to FIX at the edge where count reaches 0 (edges E1..EN).
//   FIX: At edge EN+1, apply sign correction, register hi/lo, set prodv=1 and busy=0, then go to IDLE.
//  Latency: prodv is high in the cycle after edge E(N+1). For W=32, BPC=1 that is 33 edges after the start edge.
//  hi/lo hold their values until the next FIX. prodv is high exactly one cycle.
//  An mst arriving in the prodv cycle is accepted, because the state is already IDLE.
//  mst while busy: ignored, no queueing. Operands are captured only at E0; later changes on a/b are don't-care.
//  Sign rules:
//   mul: product = a*b as a 2W-bit result, two's complement when msgn.
//   div: quotient truncates toward zero; remainder takes the dividend's sign.
//  Boundary cases:
//   b=0, div: lo = all-ones, hi = a (signed and unsigned alike). Normal latency, no exception.
//   signed div, a = -2^(W-1), b = -1: lo = -2^(W-1) (0x8000_0000 for W=32), hi = 0.
//   a = -2^(W-1) magnitude: compute the magnitude in W+1 bits internally so no overflow occurs.
//   mul by 0 and div of 0: still run the full N cycles (fixed latency, no early-out).
// STRUCTURE
//  Shared package muldiv_pkg:
//   state enum {IDLE, RUN, FIX}
//   localparam encodings OP_MUL=0 / OP_DIV=1
//   function abs_ext(W+1)
//  Sub-module muldiv_step: combinational single-bit step (add-shift or trial subtract), instantiated
//  BPC times in a chain inside RUN.
//  Datapath: one 2W+1-bit accumulator/remainder-quotient register, a W+1-bit operand register and a
//  $clog2(N+1) counter.
// TESTING
//  All cases below use WIDTH=32 unless stated; every case also checks prodv at exactly N+1 edges.
//  1. mul signed,   a=0x7FFFFFFF, b=0x80000000 -> {hi,lo}=0xC0000000_80000000, prodv at edge E33
//  2. mul unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF -> {hi,lo}=0xFFFFFFFE_00000001;
//     the same operands signed -> 0x00000000_00000001
//  3. div signed,   a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1);
//     the same operands unsigned -> lo=0x7FFFFFFC, hi=1
//  4. div by 0, a=0x12345678 -> lo=0xFFFFFFFF, hi=0x12345678;
//     signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0
//  5. Pulse mst again at E5 with other operands -> ignored, first result returned.
//     Deassert rst at E10 -> hi=lo=0, busy=0, no prodv.
//     A new mst afterwards completes normally.
//  6. Re-run cases 1-4 with BPC=2 and BPC=4 (prodv at E17 / E9), and with WIDTH=16, BPC=1.
//     Add 1000 random op/sign/operand vectors checked against a $signed/$unsigned reference model.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types, op encodings and magnitude helper for the serial mul/div unit
package muldiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  localparam int MAXW = 64;
  // Caller sign- or zero-extends into MAXW+1 bits, so |-2^(W-1)| never overflows.
  function automatic logic [MAXW:0] abs_ext(input logic [MAXW:0] v);
    return v[MAXW] ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational bit step of the serial datapath
//   acc  in   2W+1  {partial result (W+1), multiplier / dividend bits (W)}
//   op   in   W+1   multiplicand / divisor magnitude
//   div  in   1     0 = add-shift (mul), 1 = restoring trial subtract (div)
//   nxt  out  2W+1  accumulator after one bit
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH:0]   op,
  input  logic             div,
  output logic [2*WIDTH:0] nxt
);
  logic [WIDTH:0] sum, rem, diff;
  always_comb begin
    sum = acc[2*WIDTH:WIDTH] + (acc[0] ? op : '0);
    rem = acc[2*WIDTH-1:WIDTH-1];
    diff = rem - op;
    nxt = div ? (rem >= op ? {diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-1:0], 1'b0})
              : {1'b0, sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_serial.sv
// muldiv_serial: iterative signed/unsigned multiply/divide for the HI/LO path
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-low reset
//   mst    in   1      start request (ignored while busy)
//   msgn   in   1      1 = signed operands
//   mdiv   in   1      0 = multiply, 1 = divide
//   a, b   in   WIDTH  multiplicand/dividend, multiplier/divisor
//   hi     out  WIDTH  product high half / remainder
//   lo     out  WIDTH  product low half / quotient
//   prodv  out  1      one-cycle pulse when hi/lo update
//   busy   out  1      operation in flight
module muldiv_serial
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mst,
  input  logic             msgn,
  input  logic             mdiv,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             prodv,
  output logic             busy
);
  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N + 1);
  if (WIDTH % BPC != 0 || (BPC != 1 && BPC != 2 && BPC != 4) || WIDTH % 2 != 0 || WIDTH < 8 || WIDTH > MAXW) begin : g_bad
    $error("muldiv_serial: unsupported WIDTH/BPC");
  end
  state_t             state, state_nxt;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   chain [BPC+1];
  logic [WIDTH:0]     op, ma, mb;
  logic               md, neg_q, neg_r;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  assign ma = (WIDTH+1)'(abs_ext({{(MAXW+1-WIDTH){msgn & a[WIDTH-1]}}, a}));
  assign mb = (WIDTH+1)'(abs_ext({{(MAXW+1-WIDTH){msgn & b[WIDTH-1]}}, b}));
  assign chain[0] = acc;
  for (genvar i = 0; i < BPC; i++) begin : g_step
    muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc(chain[i]),
      .op (op),
      .div(md),
      .nxt(chain[i+1])
    );
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (mst ? RUN : IDLE)
              : state == RUN  ? (cnt == CW'(1) ? FIX : RUN)
              : IDLE;
  always_comb busy = state != IDLE;
  // neg_q doubles as the product sign for multiply.
  always_comb begin
    prod = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {acc, op, md, neg_q, neg_r, cnt, hi, lo, prodv} <= '0;
    end else begin
      prodv <= state == FIX;
      if (state == IDLE && mst) begin
        acc <= {{WIDTH{1'b0}}, ma};
        op <= mb;
        md <= mdiv;
        // Divide by zero keeps the quotient positive so it reads back as all-ones.
        neg_q <= msgn & (a[WIDTH-1] ^ b[WIDTH-1]) & (mdiv == OP_MUL || b != '0);
        neg_r <= msgn & a[WIDTH-1];
        cnt <= CW'(N);
      end else if (state == RUN) begin
        acc <= chain[BPC];
        cnt <= cnt - CW'(1);
      end else if (state == FIX) begin
        hi <= md == OP_DIV ? rem : prod[2*WIDTH-1:WIDTH];
        lo <= md == OP_DIV ? quo : prod[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_muldiv_serial.sv
// tb_muldiv_serial: scoreboard bench for four muldiv_serial configurations against an arithmetic model
module tb_muldiv_serial;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  localparam int WS [4] = '{32, 32, 32, 16};
  localparam int NS [4] = '{32, 16, 8, 16};
  logic        clk = 0, rst = 0, mst = 0, msgn = 0, mdiv = 0;
  logic [31:0] a = 0, b = 0;
  logic [31:0] hi_o [4];
  logic [31:0] lo_o [4];
  logic        pv [4];
  logic        bz [4];
  logic [15:0] hi16, lo16;
  int          cyc = 0, tests = 0, fails = 0;
  exp_t        sb [4][$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  muldiv_serial #(.WIDTH(32), .BPC(1)) u0 (.clk(clk), .rst(rst), .mst(mst), .msgn(msgn), .mdiv(mdiv), .a(a), .b(b),
    .hi(hi_o[0]), .lo(lo_o[0]), .prodv(pv[0]), .busy(bz[0]));
  muldiv_serial #(.WIDTH(32), .BPC(2)) u1 (.clk(clk), .rst(rst), .mst(mst), .msgn(msgn), .mdiv(mdiv), .a(a), .b(b),
    .hi(hi_o[1]), .lo(lo_o[1]), .prodv(pv[1]), .busy(bz[1]));
  muldiv_serial #(.WIDTH(32), .BPC(4)) u2 (.clk(clk), .rst(rst), .mst(mst), .msgn(msgn), .mdiv(mdiv), .a(a), .b(b),
    .hi(hi_o[2]), .lo(lo_o[2]), .prodv(pv[2]), .busy(bz[2]));
  muldiv_serial #(.WIDTH(16), .BPC(1)) u3 (.clk(clk), .rst(rst), .mst(mst), .msgn(msgn), .mdiv(mdiv), .a(a[15:0]), .b(b[15:0]),
    .hi(hi16), .lo(lo16), .prodv(pv[3]), .busy(bz[3]));
  assign hi_o[3] = {16'd0, hi16};
  assign lo_o[3] = {16'd0, lo16};
  function automatic logic [63:0] ref_hl(input int w, input bit sg, input bit dv, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] mask, au, bu, p, q, r;
    longint      sa, sb_;
    mask = (64'd1 << w) - 64'd1;
    au = {32'd0, av} & mask;
    bu = {32'd0, bv} & mask;
    sa = sg ? (longint'(au << (64 - w)) >>> (64 - w)) : longint'(au);
    sb_ = sg ? (longint'(bu << (64 - w)) >>> (64 - w)) : longint'(bu);
    if (!dv) begin
      p = 64'(sa * sb_);
      return {32'((p >> w) & mask), 32'(p & mask)};
    end
    if (bu == 0) return {32'(au), 32'(mask)};
    if (sg) begin
      q = 64'(sa / sb_);
      r = 64'(sa % sb_);
    end else begin
      q = au / bu;
      r = au % bu;
    end
    return {32'(r & mask), 32'(q & mask)};
  endfunction
  task automatic issue(input bit sg, input bit dv, input logic [31:0] av, input logic [31:0] bv);
    int   t;
    exp_t e;
    logic [63:0] r;
    t = 0;
    while ((bz[0] | bz[1] | bz[2] | bz[3]) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      tests++;
      fails++;
      $display("FAIL busy_timeout: busy still %b%b%b%b after %0d cycles, required idle", bz[0], bz[1], bz[2], bz[3], t);
    end
    for (int k = 0; k < 4; k++) begin
      r = ref_hl(WS[k], sg, dv, av, bv);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.cyc = cyc + NS[k] + 2;
      sb[k].push_back(e);
    end
    msgn = sg;
    mdiv = dv;
    a = av;
    b = bv;
    mst = 1;
    @(negedge clk);
    mst = 0;
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return 32'hFFFF_8000;
      default: return $urandom;
    endcase
  endfunction
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (!rst) begin
        tests++;
        if (hi_o[k] !== 0 || lo_o[k] !== 0 || pv[k] !== 0 || bz[k] !== 0) begin
          fails++;
          $display("FAIL reset[%0d]: hi=%h lo=%h prodv=%b busy=%b, required all zero", k, hi_o[k], lo_o[k], pv[k], bz[k]);
        end
      end else if (pv[k]) begin
        tests++;
        if (sb[k].size() == 0) begin
          fails++;
          $display("FAIL spurious[%0d]: prodv with nothing pending, hi=%h lo=%h", k, hi_o[k], lo_o[k]);
        end else begin
          e = sb[k].pop_front();
          if (hi_o[k] !== e.hi || lo_o[k] !== e.lo || cyc != e.cyc) begin
            fails++;
            $display("FAIL result[%0d]: got hi=%h lo=%h at cycle %0d, required hi=%h lo=%h at cycle %0d",
                     k, hi_o[k], lo_o[k], cyc, e.hi, e.lo, e.cyc);
          end
        end
      end
    end
  end
  initial begin
    int t;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    issue(1, 0, 32'h7FFF_FFFF, 32'h8000_0000);
    issue(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(1, 1, 32'hFFFF_FFF9, 32'h2);
    issue(0, 1, 32'hFFFF_FFF9, 32'h2);
    issue(0, 1, 32'h1234_5678, 32'h0);
    issue(1, 1, 32'h8765_4321, 32'h0);
    issue(1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(1, 1, 32'hFFFF_8000, 32'hFFFF_FFFF);
    issue(1, 0, 32'h0, 32'hFFFF_FFFF);
    issue(1, 1, 32'h0, 32'h5);
    issue(0, 1, 32'hFFFF_FFFF, 32'h1);
    // second start while busy must be dropped
    issue(0, 0, 32'h0000_1234, 32'h0000_5678);
    repeat (4) @(negedge clk);
    a = 32'hDEAD_BEEF;
    b = 32'h0000_0003;
    mdiv = 1;
    mst = 1;
    @(negedge clk);
    mst = 0;
    // abort an operation mid-flight
    issue(1, 1, 32'h8123_4567, 32'h0000_0071);
    repeat (6) @(negedge clk);
    #2 rst = 0;
    for (int k = 0; k < 4; k++) sb[k].delete();
    repeat (3) @(negedge clk);
    #2 rst = 1;
    repeat (40) @(negedge clk);
    issue(1, 0, 32'hFFFF_FFFE, 32'h0000_0003);
    for (int i = 0; i < 1000; i++) issue(1'($urandom), 1'($urandom), pick(), pick());
    t = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (sb[k].size() != 0) begin
        fails++;
        $display("FAIL drain[%0d]: %0d results outstanding, required 0", k, sb[k].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
